// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: shadows EX/MEM/WB and derives stall, flush and forwarding selects.
// Stall/flush/forward are same-cycle combinational; no backpressure beyond the stall it generates.
module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int FORWARD_EN  = 1,
  parameter int ZERO_REG_HW = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_source,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_dst,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             v;
    logic             wb;
    logic             mr;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] s1;
    logic [REG_W-1:0] s2;
    logic             two;
  } slot_t;

  slot_t            ex_q, mem_q, wb_q, id_slot;
  logic [CNT_W-1:0] cnt_q;
  logic             ex_hit, mem_hit, raw;

  function automatic logic writer_match(input slot_t x, input logic [REG_W-1:0] r);
    return x.v && x.wb && (x.dst == r) && !((ZERO_REG_HW != 0) && (r == '0));
  endfunction

  // Loads sitting in MEM have no data yet, so they are only ever forwarded from WB.
  function automatic logic [1:0] fwd_pick(input slot_t m, input slot_t w,
                                          input logic [REG_W-1:0] r);
    if (writer_match(m, r) && !m.mr) return 2'b01;
    if (writer_match(w, r))          return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    id_slot = '{v: id_valid, wb: id_wb_en, mr: id_mem_read, dst: id_dst,
                s1: id_src1, s2: id_src2, two: id_two_source};
    ex_hit  = writer_match(ex_q, id_src1) | (id_two_source & writer_match(ex_q, id_src2));
    mem_hit = writer_match(mem_q, id_src1) | (id_two_source & writer_match(mem_q, id_src2));
    if (FORWARD_EN != 0) raw = id_valid & ex_q.mr & ex_hit;
    else                 raw = id_valid & (ex_hit | mem_hit);
  end

  always_comb begin
    stall       = raw & ~ex_branch_taken & ~rst;
    flush_if_id = ex_branch_taken & ~rst;
    flush_id_ex = ex_branch_taken & ~rst;
    fwd_sel_a   = 2'b00;
    fwd_sel_b   = 2'b00;
    if (!rst && (FORWARD_EN != 0) && ex_q.v) begin
      fwd_sel_a = fwd_pick(mem_q, wb_q, ex_q.s1);
      if (ex_q.two) fwd_sel_b = fwd_pick(mem_q, wb_q, ex_q.s2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      ex_q  <= (stall || flush_id_ex) ? '0 : id_slot;
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard across four parameterisations sharing one stimulus bus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_source, id_wb_en, id_mem_read, ex_branch_taken;
  logic [4:0] id_src1, id_src2, id_dst;

  // d0: default, d1: zero-reg hardwired, d2: no forwarding, d3: 4-bit counter
  logic       st0, fi0, fe0, st1, fi1, fe1, st2, fi2, fe2, st3, fi3, fe3;
  logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2, fa3, fb3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(5), .FORWARD_EN(1), .ZERO_REG_HW(0), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_source(id_two_source), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall(st0), .flush_if_id(fi0),
    .flush_id_ex(fe0), .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_count(cnt0));

  hazard_scoreboard #(.REG_W(5), .FORWARD_EN(1), .ZERO_REG_HW(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_source(id_two_source), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall(st1), .flush_if_id(fi1),
    .flush_id_ex(fe1), .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_count(cnt1));

  hazard_scoreboard #(.REG_W(5), .FORWARD_EN(0), .ZERO_REG_HW(0), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_source(id_two_source), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall(st2), .flush_if_id(fi2),
    .flush_id_ex(fe2), .fwd_sel_a(fa2), .fwd_sel_b(fb2), .stall_count(cnt2));

  hazard_scoreboard #(.REG_W(5), .FORWARD_EN(1), .ZERO_REG_HW(0), .CNT_W(4)) d3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_source(id_two_source), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall(st3), .flush_if_id(fi3),
    .flush_id_ex(fe3), .fwd_sel_a(fa3), .fwd_sel_b(fb3), .stall_count(cnt3));

  typedef struct {
    logic       v;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       two;
    logic       wb;
    logic       mr;
    logic [4:0] dst;
    logic       br;
    logic       e_st;
    logic       e_fl;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    int         e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic two, input logic wb, input logic mr,
                       input logic [4:0] dst, input logic br);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_source = two;
    id_wb_en = wb; id_mem_read = mr; id_dst = dst; ex_branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //         v  s1  s2  two wb mr dst br | st fl fa fb cnt
    tbl[0]  = '{1, 1,  2,  0, 1, 1,  3, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{1, 3,  0,  1, 1, 0,  4, 0,   1, 0, 0, 0, 0};
    tbl[2]  = '{1, 3,  0,  1, 1, 0,  4, 0,   0, 0, 0, 0, 1};
    tbl[3]  = '{1, 1,  2,  1, 1, 0,  5, 0,   0, 0, 2, 0, 1};
    tbl[4]  = '{1, 7,  5,  1, 1, 0,  8, 0,   0, 0, 0, 0, 1};
    tbl[5]  = '{1, 9,  5,  1, 0, 0,  0, 0,   0, 0, 0, 1, 1};
    tbl[6]  = '{0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 0, 2, 1};
    tbl[7]  = '{1, 0,  0,  0, 1, 1, 10, 0,   0, 0, 0, 0, 1};
    tbl[8]  = '{1, 10, 0,  0, 0, 0,  0, 1,   0, 1, 0, 0, 1};
    tbl[9]  = '{0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 1};
    tbl[10] = '{1, 0,  0,  0, 1, 1, 11, 0,   0, 0, 0, 0, 1};
    tbl[11] = '{1, 11, 11, 1, 0, 0,  0, 0,   1, 0, 0, 0, 1};
    tbl[12] = '{1, 11, 11, 1, 0, 0,  0, 0,   0, 0, 0, 0, 2};
    tbl[13] = '{0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 2, 2, 2};
    tbl[14] = '{1, 0,  0,  0, 1, 0, 12, 0,   0, 0, 0, 0, 2};
    tbl[15] = '{1, 1,  0,  0, 1, 0, 12, 0,   0, 0, 0, 0, 2};
    tbl[16] = '{1, 12, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 2};
    tbl[17] = '{0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 1, 0, 2};

    do_reset();
    tick();
    chk("reset_stall", st0, 0);
    chk("reset_cnt", cnt0, 0);
    chk("reset_fwd_a", fa0, 0);

    // Main table on d0: load-use, ALU forwarding, branch vs stall, dual-source, MEM-over-WB
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].wb, tbl[i].mr,
            tbl[i].dst, tbl[i].br);
      #1;
      chk($sformatf("v%0d_stall", i), st0, tbl[i].e_st);
      chk($sformatf("v%0d_flush_if_id", i), fi0, tbl[i].e_fl);
      chk($sformatf("v%0d_flush_id_ex", i), fe0, tbl[i].e_fl);
      chk($sformatf("v%0d_fwd_a", i), fa0, tbl[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), fb0, tbl[i].e_fb);
      chk($sformatf("v%0d_cnt", i), cnt0, tbl[i].e_cnt);
      tick();
    end

    // Zero register: d1 hardwires r0, d0 does not
    do_reset();
    drive(1, 1, 2, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zr_alu_d0_stall", st0, 0);
    chk("zr_alu_d1_stall", st1, 0);
    tick();
    drive(1, 1, 0, 0, 1, 1, 0, 0);
    #1;
    chk("zr_fwd_d0", fa0, 1);
    chk("zr_fwd_d1", fa1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zr_load_d0_stall", st0, 1);
    chk("zr_load_d1_stall", st1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zr_d0_cnt", cnt0, 1);
    chk("zr_d1_cnt", cnt1, 0);

    // No forwarding: d2 stalls 2 cycles behind an ALU producer
    do_reset();
    drive(1, 1, 2, 0, 1, 0, 7, 0);
    #1;
    chk("nf_c1_stall", st2, 0);
    tick();
    drive(1, 7, 0, 0, 0, 0, 0, 0);
    #1;
    chk("nf_c2_stall", st2, 1);
    chk("nf_c2_fwd_a", fa2, 0);
    tick();
    chk("nf_c3_stall", st2, 1);
    tick();
    chk("nf_c4_stall", st2, 0);
    chk("nf_c4_cnt", cnt2, 2);
    tick();
    drive(1, 1, 2, 0, 1, 0, 9, 0);
    #1;
    chk("nf_c5_fwd_a", fa2, 0);
    chk("nf_c5_stall", st2, 0);
    tick();
    drive(1, 1, 9, 0, 0, 0, 0, 0);
    #1;
    chk("nf_src2_unused_stall", st2, 0);
    id_two_source = 1'b1;
    #1;
    chk("nf_src2_used_stall", st2, 1);

    // Saturation: self-dependent load stream stalls every other cycle
    do_reset();
    drive(1, 3, 0, 0, 1, 1, 3, 0);
    for (int c = 1; c <= 40; c++) begin
      #1;
      chk($sformatf("sat_c%0d_stall", c), st3, (c % 2 == 0) ? 1 : 0);
      tick();
    end
    chk("sat_d0_cnt", cnt0, 20);
    chk("sat_d3_cnt", cnt3, 15);
    tick();
    chk("sat_c42_stall", st3, 1);
    chk("sat_c42_cnt", cnt3, 15);

    // Reset asserted mid-stall
    rst = 1'b1;
    #1;
    chk("rst_stall_forced", st3, 0);
    ex_branch_taken = 1'b1;
    #1;
    chk("rst_flush_if_id_forced", fi3, 0);
    chk("rst_flush_id_ex_forced", fe3, 0);
    chk("rst_fwd_a_forced", fa3, 0);
    tick();
    chk("rst_cnt_d3", cnt3, 0);
    chk("rst_cnt_d0", cnt0, 0);
    rst = 1'b0;
    ex_branch_taken = 1'b0;
    #1;
    chk("post_rst_stall", st3, 0);
    chk("post_rst_fwd_a", fa3, 0);
    tick();
    chk("post_rst_resume_stall", st3, 1);
    tick();
    chk("post_rst_cnt", cnt3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer-side control for the ID/EX pipeline register. It decides each cycle whether that register loads the decoded instruction, loads a bubble, or is flushed.
- Keeps a 3-slot shadow of the instructions in EX, MEM and WB (destination, writeback enable, memory read, sources).
- From that shadow it generates stall, flush and forwarding selects for the 5-stage core.
- Sits beside the ID stage. It drives the ID/EX flush input and the IF/ID and PC freeze signals.

Parameters:
- REG_W, 5, register index width (matches the dst field of the ID/EX register).
- FORWARD_EN, 1, 1 = forwarding active, stall only on load-use; 0 = stall on any RAW hazard against EX or MEM.
- ZERO_REG_HW, 0, 1 = register index 0 is hardwired zero and never causes a hazard.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_W  first source register of the instruction in ID
- id_src2  in  REG_W  second source register of the instruction in ID
- id_two_source  in  1  id_src2 is actually read
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- id_dst  in  REG_W  ID instruction destination
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- stall  out  1  freeze PC and IF/ID; ID/EX loads a bubble
- flush_if_id  out  1  clear IF/ID
- flush_id_ex  out  1  clear ID/EX (drives its flush input)
- fwd_sel_a  out  2  EX operand A source: 00 register file, 01 MEM result, 10 WB result
- fwd_sel_b  out  2  EX operand B source, same encoding
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot contents:
  - Each slot (EX, MEM, WB) holds {v, wb, mr, dst, s1, s2, two}.
  - "Writer match" of slot X against register r: X.v & X.wb & X.dst==r & !(ZERO_REG_HW & r==0).
- Slot update on every rising clk when rst=0:
  - MEM <= EX.
  - WB <= MEM.
  - EX <= bubble (v=0, all fields 0) if stall or flush_id_ex.
  - Otherwise EX <= {id_valid, id_wb_en, id_mem_read, id_dst, id_src1, id_src2, id_two_source}.
- Hazard detection (combinational):
  - src1 hit(X) = writer match of X on id_src1.
  - src2 hit(X) = id_two_source & writer match of X on id_src2.
  - FORWARD_EN=1: raw = id_valid & EX.mr & (src1 hit(EX) | src2 hit(EX)).
  - FORWARD_EN=0: raw = id_valid & (any hit on EX or MEM).
  - The WB slot never causes a hazard; the register file writes before ID reads.
- Branch priority:
  - flush_if_id = flush_id_ex = ex_branch_taken.
  - stall = raw & !ex_branch_taken. The wrong-path instruction is dropped, not stalled.
- Forwarding (combinational, for the instruction in EX):
  - fwd_sel_a = 01 if writer match of MEM on EX.s1; else 10 if writer match of WB on EX.s1; else 00.
  - fwd_sel_b: same rule on EX.s2, gated by EX.two.
  - MEM has priority over WB.
  - FORWARD_EN=0 or EX.v=0: both selects are 00.
  - Loads in MEM are never forwarded from MEM. A load-use stall guarantees the load has reached WB before it is consumed.
- stall_count:
  - Increments on each clk edge where stall=1.
  - Saturates at all-ones; no wrap.
- Reset (synchronous, rst=1 at a clk edge):
  - All slots become bubbles; stall_count=0.
  - While rst=1, stall, flush_if_id, flush_id_ex are forced to 0 and fwd_sel_a/b to 00.
  - Reset mid-stall discards the stalled state; the first cycle after reset sees empty slots.
- Latency:
  - stall and flush are same-cycle combinational.
  - A load-use stall lasts exactly 1 cycle. The bubble enters EX and the load moves to MEM, so raw drops.
  - FORWARD_EN=0: a dependent instruction stalls 2 cycles after a producer in EX, 1 cycle after a producer in MEM.
- Simultaneous events:
  - Branch taken during a load-use condition: flush wins, stall=0, stall_count unchanged.
  - Both sources match: a single stall.
  - Writer matches in both MEM and WB: the MEM match wins.

Test Plan:
- Load-use, FORWARD_EN=1: load r3 enters EX, then ID presents src1=3 with id_valid=1 -> stall=1 for exactly 1 cycle, EX slot bubble, stall_count=1. On the next cycle the dependent instruction enters EX with fwd_sel_a=10.
- ALU forwarding: ALU writes r5, next instruction reads r5 on src2 with two_source=1 -> stall=0; when the reader is in EX, fwd_sel_b=01 on that cycle. With a gap of one instruction, fwd_sel_b=10.
- Branch vs stall: load-use condition and ex_branch_taken=1 in the same cycle -> stall=0, flush_if_id=flush_id_ex=1, EX slot bubble, stall_count unchanged.
- Zero register, ZERO_REG_HW=1: load writes r0, next instruction reads r0 -> no stall, fwd_sel 00. With ZERO_REG_HW=0 -> 1-cycle stall.
- FORWARD_EN=0: ALU writes r7, next reads r7 -> stall for 2 cycles, selects stay 00. If two_source=0 and only src2 matches -> no stall.
- Reset and saturation: with CNT_W=4, hold a hazard for 20 cycles -> stall_count=15. Assert rst for 1 cycle mid-stall -> outputs 0 during reset, stall_count=0, all slots empty afterwards.
